// File: rtl/project_pkg.sv
`default_nettype none
// ============================================================================
// project_pkg : shared state types and default SRAM bus widths for the top
// Revision 1.0
// ============================================================================
package project_pkg;

    localparam int DEFAULT_ADDR_W = 18;
    localparam int DEFAULT_DATA_W = 16;

    typedef enum logic [1:0] {
        S_TOP_IDLE,
        S_TOP_UART_RX,
        S_TOP_DECODE,
        S_TOP_DISPLAY
    } top_state_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_LAUNCH,
        S_RUN,
        S_NEXT,
        S_DISPLAY,
        S_ERROR
    } seq_state_e;

    typedef enum logic [1:0] {
        OWNER_IDLE,
        OWNER_CLIENT,
        OWNER_DISPLAY
    } sram_owner_e;

    function automatic logic [7:0] phase_onehot(input logic [2:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_client_mux.sv
`default_nettype none
// ============================================================================
// sram_client_mux : N-to-1 SRAM port select with display and forced-idle modes
// Revision 1.0
// ============================================================================
module sram_client_mux
    import project_pkg::*;
#(
    parameter int NUM_CLIENTS = 3,
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int DATA_W      = DEFAULT_DATA_W
) (
    input  sram_owner_e                     owner_i,
    input  logic [2:0]                      sel_i,
    input  logic [NUM_CLIENTS*ADDR_W-1:0]   client_address_i,
    input  logic [NUM_CLIENTS*DATA_W-1:0]   client_write_data_i,
    input  logic [NUM_CLIENTS-1:0]          client_we_n_i,
    input  logic [ADDR_W-1:0]               display_address_i,
    output logic [ADDR_W-1:0]               sram_address_o,
    output logic [DATA_W-1:0]               sram_write_data_o,
    output logic                            sram_we_n_o
);

    always_comb begin
        sram_address_o    = '0;
        sram_write_data_o = '0;
        sram_we_n_o       = 1'b1;
        case (owner_i)
            OWNER_CLIENT: begin
                for (int i = 0; i < NUM_CLIENTS; i++) begin
                    if (sel_i == 3'(i)) begin
                        sram_address_o    = client_address_i[i*ADDR_W +: ADDR_W];
                        sram_write_data_o = client_write_data_i[i*DATA_W +: DATA_W];
                        sram_we_n_o       = client_we_n_i[i];
                    end
                end
            end
            // The VGA reader only ever reads, so writes stay blocked.
            OWNER_DISPLAY: sram_address_o = display_address_i;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/sram_phase_sequencer.sv
`default_nettype none
// ============================================================================
// sram_phase_sequencer : runs NUM_PHASES SRAM clients in order, then the display.
// Optional watchdog per phase when PHASE_TIMEOUT_EN is defined. Revision 1.0
// ============================================================================
module sram_phase_sequencer
    import project_pkg::*;
#(
    parameter int NUM_PHASES     = 3,
    parameter int ADDR_W         = DEFAULT_ADDR_W,
    parameter int DATA_W         = DEFAULT_DATA_W,
    parameter int START_DELAY    = 10,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                           CLOCK_50_I,
    input  logic                           resetn,
    input  logic                           go,
    input  logic [NUM_PHASES-1:0]          phase_done,
    input  logic [NUM_PHASES*ADDR_W-1:0]   client_address,
    input  logic [NUM_PHASES*DATA_W-1:0]   client_write_data,
    input  logic [NUM_PHASES-1:0]          client_we_n,
    input  logic [ADDR_W-1:0]              display_address,
    output logic [NUM_PHASES-1:0]          phase_start,
    output logic [ADDR_W-1:0]              SRAM_address,
    output logic [DATA_W-1:0]              SRAM_write_data,
    output logic                           SRAM_we_n,
    output logic                           display_enable,
    output logic                           busy,
    output logic [2:0]                     active_phase,
    output logic                           timeout_error
);

    seq_state_e              state_q;
    logic [7:0]              delay_q;
    logic [2:0]              phase_q;
    logic [2:0]              phase_next_d;
    logic [NUM_PHASES-1:0]   start_q;
    logic                    display_q;
    logic                    busy_q;
    logic                    w_done_sel;
    sram_owner_e             w_owner;

`ifdef PHASE_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [WD_W-1:0]         wd_q;
    logic                    tmo_q;
`endif

    assign phase_next_d = phase_q + 3'd1;

    // Only the active client's done is looked at; the others are don't-care.
    always_comb begin
        w_done_sel = 1'b0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (phase_q == 3'(i)) w_done_sel = phase_done[i];
        end
    end

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            delay_q   <= '0;
            phase_q   <= '0;
            start_q   <= '0;
            display_q <= 1'b0;
            busy_q    <= 1'b0;
`ifdef PHASE_TIMEOUT_EN
            wd_q      <= '0;
            tmo_q     <= 1'b0;
`endif
        end else begin
            start_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (go) begin
                        state_q <= S_DELAY;
                        delay_q <= '0;
                        phase_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_DELAY: begin
                    if (delay_q == 8'(START_DELAY)) begin
                        state_q <= S_LAUNCH;
                        start_q <= NUM_PHASES'(phase_onehot(phase_q));
                    end else begin
                        delay_q <= delay_q + 8'd1;
                    end
                end
                S_LAUNCH: begin
                    state_q <= S_RUN;
`ifdef PHASE_TIMEOUT_EN
                    wd_q    <= '0;
`endif
                end
                S_RUN: begin
                    // A done on the final watchdog cycle still counts as success.
                    if (w_done_sel) begin
                        state_q <= S_NEXT;
                    end
`ifdef PHASE_TIMEOUT_EN
                    else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        state_q <= S_ERROR;
                        tmo_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        wd_q    <= wd_q + 1'b1;
                    end
`endif
                end
                S_NEXT: begin
                    if (phase_q == 3'(NUM_PHASES - 1)) begin
                        state_q   <= S_DISPLAY;
                        display_q <= 1'b1;
                        busy_q    <= 1'b0;
                    end else begin
                        state_q <= S_LAUNCH;
                        phase_q <= phase_next_d;
                        start_q <= NUM_PHASES'(phase_onehot(phase_next_d));
                    end
                end
                S_DISPLAY, S_ERROR: begin
                    if (go) begin
                        state_q   <= S_DELAY;
                        delay_q   <= '0;
                        phase_q   <= '0;
                        display_q <= 1'b0;
                        busy_q    <= 1'b1;
`ifdef PHASE_TIMEOUT_EN
                        tmo_q     <= 1'b0;
`endif
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef PHASE_TIMEOUT_EN
    assign timeout_error = tmo_q;
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
    assign timeout_error        = 1'b0;
`endif

    always_comb begin
        w_owner = OWNER_IDLE;
        case (state_q)
            S_LAUNCH, S_RUN: w_owner = OWNER_CLIENT;
            S_DISPLAY:       w_owner = OWNER_DISPLAY;
            default:         w_owner = OWNER_IDLE;
        endcase
    end

    sram_client_mux #(
        .NUM_CLIENTS (NUM_PHASES),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W)
    ) u_sram_client_mux (
        .owner_i             (w_owner),
        .sel_i               (phase_q),
        .client_address_i    (client_address),
        .client_write_data_i (client_write_data),
        .client_we_n_i       (client_we_n),
        .display_address_i   (display_address),
        .sram_address_o      (SRAM_address),
        .sram_write_data_o   (SRAM_write_data),
        .sram_we_n_o         (SRAM_we_n)
    );

    assign phase_start    = start_q;
    assign display_enable = display_q;
    assign busy           = busy_q;
    assign active_phase   = phase_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_phase_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_sram_phase_sequencer : scoreboard bench for start pulses and display hand-off
// Revision 1.0
// ============================================================================
module tb_sram_phase_sequencer;

    localparam int NP = 3;
    localparam int AW = 18;
    localparam int DW = 16;
    localparam int SD = 10;
    localparam int TO = 100;

    logic             clk = 1'b0;
    logic             resetn;
    logic             go;
    logic [NP-1:0]    phase_done;
    logic [NP*AW-1:0] client_address;
    logic [NP*DW-1:0] client_write_data;
    logic [NP-1:0]    client_we_n;
    logic [AW-1:0]    display_address;
    logic [NP-1:0]    phase_start;
    logic [AW-1:0]    SRAM_address;
    logic [DW-1:0]    SRAM_write_data;
    logic             SRAM_we_n;
    logic             display_enable;
    logic             busy;
    logic [2:0]       active_phase;
    logic             timeout_error;

    always #10 clk = ~clk;

    sram_phase_sequencer #(
        .NUM_PHASES     (NP),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .START_DELAY    (SD),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLOCK_50_I        (clk),
        .resetn            (resetn),
        .go                (go),
        .phase_done        (phase_done),
        .client_address    (client_address),
        .client_write_data (client_write_data),
        .client_we_n       (client_we_n),
        .display_address   (display_address),
        .phase_start       (phase_start),
        .SRAM_address      (SRAM_address),
        .SRAM_write_data   (SRAM_write_data),
        .SRAM_we_n         (SRAM_we_n),
        .display_enable    (display_enable),
        .busy              (busy),
        .active_phase      (active_phase),
        .timeout_error     (timeout_error)
    );

    typedef struct {
        int         at;
        logic [3:0] ev;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Events: bit 3 = display_enable rising, bits 2:0 = phase_start.
    logic [3:0] mon_ev;
    logic       disp_prev = 1'b0;
    exp_t       mon_e;
    always @(negedge clk) begin
        mon_ev    = {display_enable & ~disp_prev, phase_start};
        disp_prev = display_enable;
        if (mon_ev != 4'd0) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_event", 32'(mon_ev), 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("event_value", 32'(mon_ev), 32'(mon_e.ev));
                check_eq("event_cycle", 32'(cyc), 32'(mon_e.at));
            end
        end
    end

    task automatic go_pulse();
        go = 1'b1;
        sb_q.push_back('{cyc + SD + 2, 4'b0001});
        @(negedge clk);
        go = 1'b0;
    endtask

    // Called while phase idx is in S_RUN; returns in the following LAUNCH/DISPLAY cycle.
    task automatic finish_phase(input int idx);
        logic [3:0] nxt;
        nxt = (idx == NP - 1) ? 4'b1000 : 4'(1 << (idx + 1));
        phase_done[idx] = 1'b1;
        sb_q.push_back('{cyc + 2, nxt});
        @(negedge clk);
        phase_done[idx] = 1'b0;
        check_eq("bubble_we_n", 32'(SRAM_we_n), 32'd1);
        check_eq("bubble_addr", 32'(SRAM_address), 32'd0);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_start"},   32'(phase_start),     32'd0);
        check_eq({tag, "_disp"},    32'(display_enable),  32'd0);
        check_eq({tag, "_busy"},    32'(busy),            32'd0);
        check_eq({tag, "_phase"},   32'(active_phase),    32'd0);
        check_eq({tag, "_tmo"},     32'(timeout_error),   32'd0);
        check_eq({tag, "_we_n"},    32'(SRAM_we_n),       32'd1);
        check_eq({tag, "_addr"},    32'(SRAM_address),    32'd0);
        check_eq({tag, "_wdata"},   32'(SRAM_write_data), 32'd0);
    endtask

    initial begin
        resetn            = 1'b1;
        go                = 1'b0;
        phase_done        = '0;
        client_address    = {18'h00200, 18'h3FFFF, 18'h00100};
        client_write_data = {16'h1234, 16'h5555, 16'hAAAA};
        client_we_n       = 3'b100;
        display_address   = 18'h12345;
        #1 resetn = 1'b0;
        #4 check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // First full pass through all three phases.
        go_pulse();
        check_eq("delay_busy",  32'(busy),         32'd1);
        check_eq("delay_phase", 32'(active_phase), 32'd0);
        repeat (SD + 1) @(negedge clk);
        check_eq("p0_launch_addr", 32'(SRAM_address),    32'h00100);
        check_eq("p0_launch_we",   32'(SRAM_we_n),       32'd0);
        check_eq("p0_launch_data", 32'(SRAM_write_data), 32'hAAAA);
        phase_done[2] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("p0_addr_hold",  32'(SRAM_address), 32'h00100);
            check_eq("p0_phase_hold", 32'(active_phase), 32'd0);
        end
        phase_done[2] = 1'b0;
        finish_phase(0);
        check_eq("p1_addr",  32'(SRAM_address),    32'h3FFFF);
        check_eq("p1_data",  32'(SRAM_write_data), 32'h5555);
        check_eq("p1_phase", 32'(active_phase),    32'd1);
        repeat (3) @(negedge clk);
        finish_phase(1);
        check_eq("p2_addr",  32'(SRAM_address), 32'h00200);
        check_eq("p2_we_n",  32'(SRAM_we_n),    32'd1);
        check_eq("p2_phase", 32'(active_phase), 32'd2);
        @(negedge clk);
        finish_phase(2);
        check_eq("disp_en",    32'(display_enable),  32'd1);
        check_eq("disp_addr",  32'(SRAM_address),    32'h12345);
        check_eq("disp_we_n",  32'(SRAM_we_n),       32'd1);
        check_eq("disp_wdata", 32'(SRAM_write_data), 32'd0);
        check_eq("disp_busy",  32'(busy),            32'd0);

        // Rerun from display, then reset in the middle of phase 1.
        go_pulse();
        check_eq("rerun_disp",  32'(display_enable), 32'd0);
        check_eq("rerun_busy",  32'(busy),           32'd1);
        check_eq("rerun_phase", 32'(active_phase),   32'd0);
        repeat (SD + 1) @(negedge clk);
        @(negedge clk);
        finish_phase(0);
        repeat (3) @(negedge clk);
        check_eq("pre_reset_addr", 32'(SRAM_address), 32'h3FFFF);
        #2 resetn = 1'b0;
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check_eq("post_reset_busy", 32'(busy), 32'd0);

        go_pulse();
        repeat (SD + 1) @(negedge clk);
        check_eq("restart_phase", 32'(active_phase), 32'd0);
        @(negedge clk);
        finish_phase(0);

`ifdef PHASE_TIMEOUT_EN
        repeat (TO) @(negedge clk);
        check_eq("wd_last_tmo",  32'(timeout_error), 32'd0);
        check_eq("wd_last_busy", 32'(busy),          32'd1);
        @(negedge clk);
        check_eq("wd_tmo",   32'(timeout_error), 32'd1);
        check_eq("wd_phase", 32'(active_phase),  32'd1);
        check_eq("wd_we_n",  32'(SRAM_we_n),     32'd1);
        check_eq("wd_busy",  32'(busy),          32'd0);
        go_pulse();
        check_eq("wd_clear", 32'(timeout_error), 32'd0);
        check_eq("wd_rbusy", 32'(busy),          32'd1);
        repeat (SD + 1) @(negedge clk);
        @(negedge clk);
        finish_phase(0);
`else
        repeat (10000) @(negedge clk);
        check_eq("stall_busy",  32'(busy),          32'd1);
        check_eq("stall_tmo",   32'(timeout_error), 32'd0);
        check_eq("stall_phase", 32'(active_phase),  32'd1);
`endif
        @(negedge clk);
        finish_phase(1);
        @(negedge clk);
        finish_phase(2);
        check_eq("final_disp", 32'(display_enable), 32'd1);
        repeat (3) @(negedge clk);
        check_eq("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_phase_sequencer.md
# sram_phase_sequencer

Parametrised top-level sequencer and SRAM access multiplexer for the image-decode datapath. It runs NUM_PHASES processing units (e.g. UART load, Milestone 1, Milestone 2) strictly in order using a start/done handshake, grants the single SRAM controller port to the active unit only, and then hands the SRAM to the VGA reader with display enabled. It replaces the hard-wired, single-unit SRAM steering in the top level with a generic, N-client, error-checked sequencer.

## Interface
- NUM_PHASES, 3, number of sequenced SRAM clients (1..8); phase 0 runs first
- ADDR_W, 18, SRAM address width
- DATA_W, 16, SRAM data width
- START_DELAY, 10, idle cycles between accepting go and launching phase 0 (0..255)
- TIMEOUT_CYCLES, 50_000_000, per-phase watchdog limit (used only with PHASE_TIMEOUT_EN)
- CLOCK_50_I  in  1  system clock, 50 MHz
- resetn  in  1  asynchronous, active-low reset
- go  in  1  start/restart request, level-sampled
- phase_done  in  NUM_PHASES  per-client done, level
- client_address  in  NUM_PHASES*ADDR_W  packed client addresses, client i at [i*ADDR_W +: ADDR_W]
- client_write_data  in  NUM_PHASES*DATA_W  packed client write data
- client_we_n  in  NUM_PHASES  per-client write enable, active-low
- display_address  in  ADDR_W  VGA reader address
- phase_start  out  NUM_PHASES  one-hot, one-cycle start pulse to client i
- SRAM_address  out  ADDR_W  to SRAM controller
- SRAM_write_data  out  DATA_W  to SRAM controller
- SRAM_we_n  out  1  to SRAM controller
- display_enable  out  1  VGA enable
- busy  out  1  high from go acceptance until display or error
- active_phase  out  3  index of current phase
- timeout_error  out  1  watchdog fired (0 when macro absent)

## Operation
- States: S_IDLE, S_DELAY, S_LAUNCH, S_RUN, S_NEXT, S_DISPLAY, S_ERROR.
- S_IDLE: outputs quiescent; go=1 -> S_DELAY, delay counter cleared, active_phase=0, busy=1.
- S_DELAY: counter increments each cycle; at count == START_DELAY -> S_LAUNCH. START_DELAY=0 goes straight to S_LAUNCH next cycle.
- S_LAUNCH: phase_start[active_phase]=1 for exactly this cycle -> S_RUN.
- S_RUN: waits phase_done[active_phase]=1. Done bits of other clients are ignored. Done already high on the first S_RUN cycle is accepted (stale-done is the client's responsibility).
- S_NEXT: one bubble cycle with SRAM_we_n forced 1; if active_phase == NUM_PHASES-1 -> S_DISPLAY, else active_phase+1 -> S_LAUNCH.
- S_DISPLAY: display_enable=1, busy=0; go=1 -> S_DELAY (full rerun, display_enable drops same edge).
- S_ERROR: timeout_error=1, busy=0, active_phase frozen on failing phase; go=1 clears error -> S_DELAY.
- SRAM mux (combinational from registered state): S_LAUNCH/S_RUN -> client[active_phase] address/data/we_n; S_DISPLAY -> display_address, we_n=1, data 0; all other states -> address 0, data 0, we_n=1.
- Reset (including mid-phase): state S_IDLE, phase_start 0, display_enable 0, busy 0, active_phase 0, timeout_error 0, SRAM_we_n 1, SRAM_address 0, SRAM_write_data 0.

## Timing
- go to phase_start[0] pulse: START_DELAY+2 cycles (go sampled edge n, S_DELAY n+1..n+1+START_DELAY, S_LAUNCH n+2+START_DELAY).
- Done of phase i to phase_start[i+1]: 2 cycles (S_NEXT, then S_LAUNCH).
- Done of last phase to display_enable=1: 2 cycles.
- Client owns SRAM from its start cycle through its done cycle inclusive; any write asserted after done is dropped.
- go held high continuously in S_DISPLAY reruns the sequence repeatedly; go is ignored in S_DELAY..S_NEXT.

## Configuration
- PHASE_TIMEOUT_EN defined: watchdog counter (ceil log2 TIMEOUT_CYCLES bits) cleared in S_LAUNCH, increments in S_RUN; reaching TIMEOUT_CYCLES-1 without done -> S_ERROR next edge. Done and timeout on the same cycle: done wins.
- Undefined: no counter, S_ERROR unreachable, timeout_error tied 0, S_RUN waits indefinitely.

## Structure
- Shared package project_pkg: sequencer state enum typedef alongside existing top-state types, default width constants (ADDR_W 18, DATA_W 16).
- One sub-module: sram_client_mux (combinational N-to-1 select of address/data/we_n with forced-idle override).

## Test plan
- NUM_PHASES=3, START_DELAY=10: go pulse at cycle 0 -> phase_start=3'b001 at cycle 12, single cycle.
- Client 0 drives address 18'h00100 with we_n=0; client 1 drives 18'h3FFFF -> SRAM_address=18'h00100 only during phase 0 S_RUN; 18'h3FFFF never appears during phase 0.
- Assert phase_done[2] during phase 0 -> ignored; phase_done[0] at cycle k -> phase_start=3'b010 at k+2; last done at m -> display_enable=1 at m+2, SRAM_address=display_address, we_n=1.
- resetn low mid-phase 1 -> all outputs at reset values asynchronously; next go restarts at phase 0.
- PHASE_TIMEOUT_EN, TIMEOUT_CYCLES=100, phase 1 never done -> timeout_error=1, active_phase=1, SRAM_we_n=1 after 100 S_RUN cycles; go recovers.
- Macro off: phase 1 stalls 10^4 cycles -> no error, busy stays 1.
